// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC CRC path.
//   state_t  - crc_arbiter FSM state encoding (IDLE/BUSY/FINALIZE)
//   owner_t  - which frame FSM holds the CRC engine (TX=0, RX=1)
//   CRC_W    - width of the CRC result
//   other_owner() - returns the opposite requester, used for round-robin
package mac_pkg;

  localparam int CRC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_FINALIZE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_TX = 1'b0,
    OWN_RX = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_TX) ? OWN_RX : OWN_TX;
  endfunction

endpackage

// File: rtl/crc_arbiter.sv
// crc_arbiter: shares one CRC engine between the frame transmitter and
// frame reception, one whole frame at a time.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   tx_req/rx_req               - requester holds high for the whole frame
//   tx_data/rx_data, *_valid    - requester byte stream
//   tx_last/rx_last             - final CRC-covered byte (with *_valid)
//   tx_grant/rx_grant           - registered ownership of the engine
//   tx_done/rx_done             - one-cycle pulse, crc_result valid
//   tx_err/rx_err               - one-cycle pulse on finalize timeout
//   crc_result                  - last captured CRC, held until next capture
//   crc_data_in/_valid, crc_en  - engine drive
//   crc_out, crc_done           - engine result
//   busy                        - arbiter is not idle
module crc_arbiter
  import mac_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_req,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  input  logic             tx_last,
  input  logic             rx_req,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_last,
  output logic             tx_grant,
  output logic             rx_grant,
  output logic             tx_done,
  output logic             rx_done,
  output logic             tx_err,
  output logic             rx_err,
  output logic [CRC_W-1:0] crc_result,
  output logic [7:0]       crc_data_in,
  output logic             crc_data_valid,
  output logic             crc_en,
  input  logic [CRC_W-1:0] crc_out,
  input  logic             crc_done,
  output logic             busy
);

  // Counter value on which the timeout fires; the counter starts at 0 on
  // FINALIZE entry, so the error lands exactly TIMEOUT_CYCLES cycles later.
  localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT_CYCLES - 1);

  state_t     state;
  owner_t     owner;
  owner_t     prio;
  owner_t     idle_pick;
  logic [4:0] fin_cnt;

  logic       own_req;
  logic       own_valid;
  logic       own_last;
  logic [7:0] own_data;

  // Select the owner's request/byte stream; the other requester never
  // reaches the engine.
  always_comb begin
    own_req   = tx_req;
    own_valid = tx_valid;
    own_last  = tx_last;
    own_data  = tx_data;
    if (owner == OWN_RX) begin
      own_req   = rx_req;
      own_valid = rx_valid;
      own_last  = rx_last;
      own_data  = rx_data;
    end
  end

  // Winner from IDLE: prio only matters when both ask at once.
  always_comb begin
    idle_pick = OWN_TX;
    if (tx_req && rx_req) idle_pick = prio;
    else if (rx_req)      idle_pick = OWN_RX;
  end

  assign crc_en         = (state == ST_BUSY);
  assign crc_data_valid = (state == ST_BUSY) && own_valid;
  assign crc_data_in    = (state == ST_BUSY) ? own_data : 8'h00;
  assign busy           = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_RX;
      prio       <= OWN_RX;
      fin_cnt    <= 5'd0;
      tx_grant   <= 1'b0;
      rx_grant   <= 1'b0;
      tx_done    <= 1'b0;
      rx_done    <= 1'b0;
      tx_err     <= 1'b0;
      rx_err     <= 1'b0;
      crc_result <= '0;
    end else begin
      tx_done <= 1'b0;
      rx_done <= 1'b0;
      tx_err  <= 1'b0;
      rx_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_req || rx_req) begin
            state    <= ST_BUSY;
            owner    <= idle_pick;
            tx_grant <= (idle_pick == OWN_TX);
            rx_grant <= (idle_pick == OWN_RX);
          end
        end
        ST_BUSY: begin
          // last wins over a simultaneous request drop
          if (own_valid && own_last) begin
            state   <= ST_FINALIZE;
            fin_cnt <= 5'd0;
          end else if (!own_req) begin
            state    <= ST_IDLE;
            tx_grant <= 1'b0;
            rx_grant <= 1'b0;
            prio     <= other_owner(prio);
          end
        end
        ST_FINALIZE: begin
          // done takes precedence over a coincident timeout
          if (crc_done) begin
            crc_result <= crc_out;
            tx_done    <= (owner == OWN_TX);
            rx_done    <= (owner == OWN_RX);
            state      <= ST_IDLE;
            tx_grant   <= 1'b0;
            rx_grant   <= 1'b0;
            prio       <= other_owner(prio);
          end else if (fin_cnt == TIMEOUT_LAST) begin
            tx_err   <= (owner == OWN_TX);
            rx_err   <= (owner == OWN_RX);
            state    <= ST_IDLE;
            tx_grant <= 1'b0;
            rx_grant <= 1'b0;
            prio     <= other_owner(prio);
          end else begin
            fin_cnt <= fin_cnt + 5'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          tx_grant <= 1'b0;
          rx_grant <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_arbiter.sv
// tb_crc_arbiter: directed, table-driven bench for crc_arbiter.
// Frames are described by a record table; multi-cycle corner cases
// (held tie, timeout, abort, mid-frame reset) are hand-written sequences.
module tb_crc_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_req, rx_req;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, rx_valid, tx_last, rx_last;
  logic        tx_grant, rx_grant, tx_done, rx_done, tx_err, rx_err;
  logic [31:0] crc_result;
  logic [7:0]  crc_data_in;
  logic        crc_data_valid, crc_en;
  logic [31:0] crc_out;
  logic        crc_done;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] expResult;

  typedef struct {
    logic        txReq;
    logic        rxReq;
    logic        expRx;
    logic [7:0]  base;
    logic [31:0] crc;
    int          delay;
  } frame_vec_t;

  frame_vec_t vecs[6];

  crc_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_req(tx_req), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .rx_req(rx_req), .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
    .tx_grant(tx_grant), .rx_grant(rx_grant),
    .tx_done(tx_done), .rx_done(rx_done), .tx_err(tx_err), .rx_err(rx_err),
    .crc_result(crc_result), .crc_data_in(crc_data_in),
    .crc_data_valid(crc_data_valid), .crc_en(crc_en),
    .crc_out(crc_out), .crc_done(crc_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Invariants: never two grants, never done together with err.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("excl", {30'd0, tx_grant & rx_grant,
                  (tx_done | rx_done) & (tx_err | rx_err)}, 32'd0);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic isRx, input logic v,
                               input logic [7:0] d, input logic l);
    if (isRx) begin
      rx_valid = v; rx_data = d; rx_last = l;
    end else begin
      tx_valid = v; tx_data = d; tx_last = l;
    end
  endtask

  // Owner streams base..base+3 while the other side drives junk that
  // must never reach the engine.
  task automatic streamFrame(input logic ownRx, input logic [7:0] base);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ownRx, 1'b1, base + 8'(i), i == 3);
      applyStimulus(!ownRx, 1'b1, 8'hEE, 1'b1);
      #1;
      checkOutput("data_in", {24'd0, crc_data_in}, {24'd0, base + 8'(i)});
      checkOutput("en_valid", {30'd0, crc_en, crc_data_valid}, 32'd3);
      stepClk();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    checkOutput("fin_en", {29'd0, crc_en, crc_data_valid, busy}, 32'd1);
  endtask

  task automatic completeFrame(input logic ownRx, input logic [31:0] crc,
                               input int delay, input logic keepOther);
    repeat (delay) stepClk();
    checkOutput("pre_done", {30'd0, tx_done, rx_done}, 32'd0);
    crc_out = crc; crc_done = 1'b1;
    stepClk();
    crc_done = 1'b0; crc_out = 32'h0;
    expResult = crc;
    checkOutput("done", {28'd0, tx_done, rx_done, tx_err, rx_err},
                {28'd0, !ownRx, ownRx, 2'b00});
    checkOutput("result", crc_result, expResult);
    checkOutput("post_grant", {29'd0, tx_grant, rx_grant, busy}, 32'd0);
    if (ownRx) rx_req = 1'b0; else tx_req = 1'b0;
    if (!keepOther) begin
      tx_req = 1'b0; rx_req = 1'b0;
    end
    stepClk();
    checkOutput("done_pulse", {30'd0, tx_done, rx_done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    tx_req = 0; rx_req = 0; tx_data = 0; rx_data = 0;
    tx_valid = 0; rx_valid = 0; tx_last = 0; rx_last = 0;
    crc_out = 0; crc_done = 0; expResult = 32'h0;

    vecs[0] = '{1'b0, 1'b1, 1'b1, 8'h01, 32'hCBF43926, 4};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h10, 32'h11112222, 2};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h20, 32'h33334444, 3};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h30, 32'h55556666, 1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h40, 32'h77778888, 0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h50, 32'h9999AAAA, 5};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out", {23'd0, tx_grant, rx_grant, tx_done, rx_done,
                tx_err, rx_err, busy, crc_en, crc_data_valid}, 32'd0);
    checkOutput("reset_result", crc_result, 32'h0);
    rst_n = 1'b1;
    stepClk();

    // Table frames: prio starts at RX and toggles after each frame.
    for (int i = 0; i < 6; i++) begin
      tx_req = vecs[i].txReq; rx_req = vecs[i].rxReq;
      stepClk();
      checkOutput("grant", {30'd0, tx_grant, rx_grant},
                  {30'd0, !vecs[i].expRx, vecs[i].expRx});
      streamFrame(vecs[i].expRx, vecs[i].base);
      completeFrame(vecs[i].expRx, vecs[i].crc, vecs[i].delay, 1'b0);
    end

    // crc_done while idle must be ignored.
    crc_out = 32'hDEADBEEF; crc_done = 1'b1;
    stepClk();
    crc_done = 1'b0; crc_out = 32'h0;
    checkOutput("idle_done", {30'd0, tx_done, rx_done}, 32'd0);
    checkOutput("idle_result", crc_result, expResult);

    // Tie with loser held: RX first, TX follows one idle edge later.
    tx_req = 1'b1; rx_req = 1'b1;
    stepClk();
    checkOutput("tie_grant_rx", {30'd0, tx_grant, rx_grant}, 32'd1);
    streamFrame(1'b1, 8'h60);
    completeFrame(1'b1, 32'hABCD0001, 2, 1'b1);
    checkOutput("tie_grant_tx", {30'd0, tx_grant, rx_grant}, 32'd2);
    streamFrame(1'b0, 8'h70);
    completeFrame(1'b0, 32'hABCD0002, 2, 1'b0);

    // Timeout: no crc_done, err exactly 16 cycles after FINALIZE entry.
    tx_req = 1'b1;
    stepClk();
    checkOutput("to_grant", {30'd0, tx_grant, rx_grant}, 32'd2);
    streamFrame(1'b0, 8'h80);
    for (int k = 1; k < 16; k++) begin
      stepClk();
      if (tx_err || !busy) checkOutput("to_early", {30'd0, tx_err, busy}, 32'd1);
    end
    stepClk();
    checkOutput("to_err", {28'd0, tx_err, rx_err, tx_done, rx_done}, 32'd8);
    checkOutput("to_result", crc_result, expResult);
    checkOutput("to_busy", {29'd0, busy, tx_grant, rx_grant}, 32'd0);
    tx_req = 1'b0;
    stepClk();
    checkOutput("to_pulse", {30'd0, tx_err, rx_err}, 32'd0);

    // Abort: owner drops req without last.
    rx_req = 1'b1;
    stepClk();
    checkOutput("ab_grant", {30'd0, tx_grant, rx_grant}, 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b0);
    stepClk();
    rx_req = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    stepClk();
    checkOutput("ab_idle", {26'd0, busy, rx_grant, crc_en, rx_done, rx_err,
                crc_data_valid}, 32'd0);
    stepClk();
    checkOutput("ab_nopulse", {28'd0, tx_done, rx_done, tx_err, rx_err}, 32'd0);
    checkOutput("ab_result", crc_result, expResult);

    // Asynchronous reset mid-BUSY.
    tx_req = 1'b1;
    stepClk();
    applyStimulus(1'b0, 1'b1, 8'h99, 1'b0);
    #1;
    checkOutput("rst_pre", {30'd0, busy, tx_grant}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_async", {25'd0, tx_grant, rx_grant, busy, crc_en,
                crc_data_valid, tx_done, rx_done}, 32'd0);
    checkOutput("rst_result", crc_result, 32'h0);
    tx_req = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    stepClk();
    rst_n = 1'b1;
    stepClk();

    // prio is back to RX after reset.
    tx_req = 1'b1; rx_req = 1'b1;
    stepClk();
    checkOutput("rst_prio", {30'd0, tx_grant, rx_grant}, 32'd1);
    tx_req = 1'b0; rx_req = 1'b0;
    stepClk();
    checkOutput("final_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
